// File: rtl/uart_loader.sv
// UART boot loader: receives an A5-framed, length-prefixed word stream over 8N1
// serial and writes it as little-endian 32-bit words into RAM from address 0.
module uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic        wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] w_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      MAX_LEN   = 17'(MAX_WORDS);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_HOLD  = 3'd4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;

    logic             rx_meta_reg;
    logic             rx_sync_reg;
    logic             rx_prev_reg;
    logic [2:0]       rx_state_reg;
    logic [CNT_W-1:0] baud_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             byte_valid_reg;
    logic             frame_err_reg;

    logic [2:0]       state_reg;
    logic [15:0]      count_reg;
    logic [1:0]       byte_idx_reg;
    logic             wr_en_reg;
    logic [31:0]      mem_addr_reg;
    logic [31:0]      w_data_reg;
    logic             cpu_hold_reg;
    logic             done_reg;
    logic             err_reg;

    logic [15:0]      len_next;

    // rx is asynchronous to clk; nothing downstream sees it before two flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_reg   <= RX_IDLE;
            baud_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_prev_reg && !rx_sync_reg) begin
                        rx_state_reg <= RX_START;
                        baud_cnt_reg <= '0;
                    end
                end
                RX_START: begin
                    // Mid-start-bit recheck rejects short glitches on the line.
                    if (baud_cnt_reg == HALF_LAST) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt_reg == BIT_LAST) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {rx_sync_reg, shift_reg[7:1]};
                        bit_idx_reg  <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == 3'd7) begin
                            rx_state_reg <= RX_STOP;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt_reg == BIT_LAST) begin
                        baud_cnt_reg <= '0;
                        if (rx_sync_reg) begin
                            byte_valid_reg <= 1'b1;
                            rx_state_reg   <= RX_IDLE;
                        end else begin
                            frame_err_reg <= 1'b1;
                            rx_state_reg  <= RX_HOLD;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                RX_HOLD: begin
                    if (rx_sync_reg) begin
                        rx_state_reg <= RX_IDLE;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    assign len_next = {shift_reg, count_reg[7:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            byte_idx_reg <= '0;
            wr_en_reg    <= 1'b0;
            mem_addr_reg <= '0;
            w_data_reg   <= '0;
            cpu_hold_reg <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (frame_err_reg) begin
                        err_reg <= 1'b1;
                    end else if (byte_valid_reg && shift_reg == SYNC_BYTE) begin
                        state_reg    <= ST_LEN_LO;
                        cpu_hold_reg <= 1'b1;
                        err_reg      <= 1'b0;
                    end
                end
                ST_LEN_LO, ST_LEN_HI, ST_DATA: begin
                    if (frame_err_reg) begin
                        // Abort: partial word dropped, completed writes stay in RAM.
                        state_reg    <= ST_IDLE;
                        err_reg      <= 1'b1;
                        cpu_hold_reg <= 1'b0;
                        byte_idx_reg <= '0;
                        w_data_reg   <= '0;
                    end else if (byte_valid_reg) begin
                        if (state_reg == ST_LEN_LO) begin
                            count_reg[7:0] <= shift_reg;
                            state_reg      <= ST_LEN_HI;
                        end else if (state_reg == ST_LEN_HI) begin
                            count_reg <= len_next;
                            if (len_next == 16'd0) begin
                                state_reg    <= ST_IDLE;
                                done_reg     <= 1'b1;
                                cpu_hold_reg <= 1'b0;
                            end else if ({1'b0, len_next} > MAX_LEN) begin
                                state_reg    <= ST_IDLE;
                                err_reg      <= 1'b1;
                                cpu_hold_reg <= 1'b0;
                            end else begin
                                state_reg    <= ST_DATA;
                                mem_addr_reg <= '0;
                                byte_idx_reg <= '0;
                            end
                        end else begin
                            w_data_reg[8*byte_idx_reg +: 8] <= shift_reg;
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            if (byte_idx_reg == 2'd3) begin
                                state_reg <= ST_WRITE;
                                wr_en_reg <= 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    count_reg <= count_reg - 1'b1;
                    // The last word leaves mem_addr on its own address so it never
                    // exceeds 4*(MAX_WORDS-1).
                    if (count_reg == 16'd1) begin
                        state_reg    <= ST_IDLE;
                        done_reg     <= 1'b1;
                        cpu_hold_reg <= 1'b0;
                    end else begin
                        state_reg    <= ST_DATA;
                        mem_addr_reg <= mem_addr_reg + 32'd4;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign wr_en    = wr_en_reg;
    assign mem_addr = mem_addr_reg;
    assign w_data   = w_data_reg;
    assign cpu_hold = cpu_hold_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serial byte streams in, RAM writes checked
// against a scoreboard of expected (address, data) pairs.
module tb_uart_loader;

    localparam int BIT = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        wr_en;
    logic [31:0] mem_addr;
    logic [31:0] w_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int          tests = 0;
    int          fails = 0;
    int          writes_seen = 0;
    int          done_seen = 0;
    logic        wr_prev = 1'b0;
    logic        done_prev = 1'b0;
    logic [63:0] exp_q[$];

    uart_loader #(.CLKS_PER_BIT(BIT), .MAX_WORDS(256)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .wr_en(wr_en),
        .mem_addr(mem_addr), .w_data(w_data), .cpu_hold(cpu_hold),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_w_data"}, w_data, 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Scoreboard side: every write is popped and compared; one line per write.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_en) begin
                writes_seen++;
                check("wr_en_one_cycle", 32'(wr_prev), 32'd0);
                check("hold_during_write", 32'(cpu_hold), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    $display("[TB] write addr=%h data=%h (expect %h %h)", mem_addr, w_data, e[63:32], e[31:0]);
                    check("write_addr", mem_addr, e[63:32]);
                    check("write_data", w_data, e[31:0]);
                end
            end
            if (done) begin
                done_seen++;
                check("done_one_cycle", 32'(done_prev), 32'd0);
                check("hold_drops_at_done", 32'(cpu_hold), 32'd0);
            end
            wr_prev   = wr_en;
            done_prev = done;
        end else begin
            wr_prev   = 1'b0;
            done_prev = 1'b0;
        end
    end

    initial begin
        int w0;
        int d0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Two-word load
        w0 = writes_seen; d0 = done_seen;
        exp_q.push_back({32'h0, 32'h12345678});
        exp_q.push_back({32'h4, 32'hDEADBEEF});
        send_byte(8'hA5);
        check("hold_after_a5", 32'(cpu_hold), 32'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("two_word_writes", 32'(writes_seen - w0), 32'd2);
        check("two_word_done", 32'(done_seen - d0), 32'd1);
        check("two_word_hold", 32'(cpu_hold), 32'd0);
        check("two_word_err", 32'(err), 32'd0);
        $display("[TB] two-word load finished");

        // Leading junk ignored
        w0 = writes_seen; d0 = done_seen;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
        check("junk_no_hold", 32'(cpu_hold), 32'd0);
        check("junk_no_write", 32'(writes_seen - w0), 32'd0);
        exp_q.push_back({32'h0, 32'h44332211});
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("one_word_writes", 32'(writes_seen - w0), 32'd1);
        check("one_word_done", 32'(done_seen - d0), 32'd1);
        $display("[TB] leading-junk load finished");

        // Zero-length load
        w0 = writes_seen; d0 = done_seen;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        check("zero_len_writes", 32'(writes_seen - w0), 32'd0);
        check("zero_len_done", 32'(done_seen - d0), 32'd1);
        check("zero_len_hold", 32'(cpu_hold), 32'd0);
        $display("[TB] zero-length load finished");

        // Oversize length (257)
        w0 = writes_seen; d0 = done_seen;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        check("oversize_err", 32'(err), 32'd1);
        check("oversize_hold", 32'(cpu_hold), 32'd0);
        check("oversize_done", 32'(done_seen - d0), 32'd0);
        check("oversize_writes", 32'(writes_seen - w0), 32'd0);
        send_byte(8'hA5);
        check("a5_clears_err", 32'(err), 32'd0);
        check("a5_sets_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h00); send_byte(8'h00);
        check("oversize_recover_done", 32'(done_seen - d0), 32'd1);
        $display("[TB] oversize length finished");

        // Framing error mid-word
        w0 = writes_seen;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
        send_byte(8'h55, 1'b0);
        check("frame_err_err", 32'(err), 32'd1);
        check("frame_err_hold", 32'(cpu_hold), 32'd0);
        check("frame_err_writes", 32'(writes_seen - w0), 32'd0);
        $display("[TB] framing error finished");

        // A one-cycle glitch between A5 and the length must not become a byte
        w0 = writes_seen; d0 = done_seen;
        exp_q.push_back({32'h0, 32'hC0FFEE01});
        send_byte(8'hA5);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'hEE); send_byte(8'hFF); send_byte(8'hC0);
        check("glitch_writes", 32'(writes_seen - w0), 32'd1);
        check("glitch_done", 32'(done_seen - d0), 32'd1);
        check("glitch_err", 32'(err), 32'd0);
        $display("[TB] glitch rejection finished");

        // Reset mid-load, then replay
        w0 = writes_seen;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02);
        check("hold_before_reset", 32'(cpu_hold), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_no_writes", 32'(writes_seen - w0), 32'd0);
        d0 = done_seen;
        exp_q.push_back({32'h0, 32'h04030201});
        exp_q.push_back({32'h4, 32'h08070605});
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i));
        end
        check("replay_writes", 32'(writes_seen - w0), 32'd2);
        check("replay_done", 32'(done_seen - d0), 32'd1);
        check("replay_hold", 32'(cpu_hold), 32'd0);
        $display("[TB] reset and replay finished");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200).
REQ-002 Parameter MAX_WORDS, default 256, largest accepted word count.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  UART serial in, idle high, 8N1, LSB first; asynchronous to clk.
REQ-006 wr_en  output  1  one-cycle RAM write strobe.
REQ-007 mem_addr  output  32  RAM byte address of current write.
REQ-008 w_data  output  32  RAM write data.
REQ-009 cpu_hold  output  1  high while a load is in progress; top level ORs it into CPU reset.
REQ-010 done  output  1  one-cycle pulse on successful load completion.
REQ-011 err  output  1  sticky error flag.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use; the synchronizer SHALL reset to 1.
REQ-013 Receiver SHALL start on a synchronized high-to-low edge, then wait CLKS_PER_BIT/2 cycles and re-sample; if high, it SHALL abort silently and return to line idle.
REQ-014 Receiver SHALL sample 8 data bits, then the stop bit, each CLKS_PER_BIT cycles after the previous sample.
REQ-015 Valid stop bit (1) SHALL produce a one-cycle internal byte_valid carrying the byte.
REQ-016 Stop bit of 0 SHALL discard the byte, set err, and move the receiver to line idle only after rx is sampled high.
REQ-017 Loader FSM states SHALL be: IDLE, LEN_LO, LEN_HI, DATA, WRITE.
REQ-018 IDLE: byte 0xA5 -> LEN_LO, cpu_hold<=1, err<=0; any other byte SHALL be ignored.
REQ-019 LEN_LO: next byte -> count[7:0]; then -> LEN_HI.
REQ-020 LEN_HI: next byte -> count[15:8]; count==0 -> IDLE with done pulse and cpu_hold<=0; count>MAX_WORDS -> IDLE with err<=1, cpu_hold<=0, no writes; else -> DATA with mem_addr<=0.
REQ-021 DATA: four bytes SHALL be assembled little-endian (first byte -> w_data[7:0]); after the 4th byte -> WRITE.
REQ-022 WRITE: wr_en SHALL be high exactly one cycle with mem_addr and w_data stable during it; next cycle mem_addr += 4 and remaining count -= 1.
REQ-023 After the write that brings remaining count to 0, FSM SHALL enter IDLE, pulse done for one cycle, and drop cpu_hold in that same cycle.
REQ-024 A framing error during LEN_LO, LEN_HI or DATA SHALL abort the load: err<=1, cpu_hold<=0, partial word discarded, FSM -> IDLE; words already written are not rolled back.
REQ-025 Byte arrival during WRITE cannot occur (WRITE lasts 1 cycle, far shorter than a byte time); no buffering is required.
REQ-026 mem_addr SHALL only hold multiples of 4; maximum address is 4*(MAX_WORDS-1).
REQ-027 wr_en SHALL never assert outside WRITE.

Reset
REQ-028 While reset_n=0: FSM=IDLE, receiver idle, wr_en=0, mem_addr=0, w_data=0, cpu_hold=0, done=0, err=0, count=0.
REQ-029 Reset asserted mid-load SHALL abort immediately with no further writes; after release, the loader SHALL wait for a fresh 0xA5.

Verification
REQ-030 Bytes A5 02 00 78 56 34 12 EF BE AD DE -> writes (0x0,0x12345678),(0x4,0xDEADBEEF), each wr_en one cycle, done pulse once, cpu_hold high from A5 stop bit to done, err=0.
REQ-031 Bytes 00 FF 3C before A5 01 00 11 22 33 44 -> leading bytes ignored; single write (0x0,0x44332211).
REQ-032 A5 00 00 -> no writes, done pulse, cpu_hold returns 0.
REQ-033 A5 01 01 (count 257 > 256) -> no writes, err=1, cpu_hold=0, no done; subsequent A5 clears err.
REQ-034 A5 01 00 AA then a byte with stop bit 0 -> err=1, no write, FSM in IDLE; 1-cycle glitch low on rx in idle -> no byte accepted.
REQ-035 Assert reset_n=0 after 2nd data byte of a 2-word load -> all outputs 0 immediately; replayed full stream afterwards completes normally.
